// File: rtl/ttab_pkg.sv
// ---------------------------------------------------------------------------
// ttab_pkg
// Shared definitions for the truth-table BIST controller:
//   - ttab_state_e : controller FSM state encoding
//   - MISR_POLY    : feedback taps of the x^16+x^12+x^5+1 signature register
//   - MISR_SEED    : value the signature register starts from
// ---------------------------------------------------------------------------
package ttab_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ttab_state_e;

  localparam logic [15:0] MISR_POLY = 16'h1021;
  localparam logic [15:0] MISR_SEED = 16'hFFFF;

endpackage

// File: rtl/ttab_misr.sv
// ---------------------------------------------------------------------------
// ttab_misr
// 16-bit serial-input signature register (poly x^16+x^12+x^5+1) that
// compresses the response stream of the function under test.
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous reset, active-low (loads the seed)
//   seed_load  in   reload the seed on this edge (start of a new sweep)
//   shift_en   in   fold din into the signature on this edge
//   din        in   serial response bit
//   sig        out  current signature
// ---------------------------------------------------------------------------
module ttab_misr
  import ttab_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        seed_load,
  input  logic        shift_en,
  input  logic        din,
  output logic [15:0] sig
);

  logic feedback;

  // The incoming bit is mixed with the bit shifted out of the top, and that
  // combined bit decides whether the polynomial taps are applied.
  always_comb begin
    feedback = sig[15] ^ din;
  end

  // Seed load wins over shifting so a restart always begins from a clean
  // signature; with neither request the signature simply holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= MISR_SEED;
    end else if (seed_load) begin
      sig <= MISR_SEED;
    end else if (shift_en) begin
      sig <= {sig[14:0], 1'b0} ^ ({16{feedback}} & MISR_POLY);
    end
  end

endmodule

// File: rtl/ttab_bist_ctrl.sv
// ---------------------------------------------------------------------------
// ttab_bist_ctrl
// Self-checking BIST controller for an N_IN-input combinational function.
// Sweeps every input vector, compares each response against the expected
// truth table EXP_TT (bit i = F at input index i) and reports the result.
// Optional feature macro: TTAB_SIGNATURE_EN adds a 16-bit MISR signature
// output (sig) built by ttab_misr.
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous reset, active-low
//   start     in   begin a sweep (ignored while a sweep runs)
//   dut_in    out  registered vector driven to the function, A is MSB
//   dut_out   in   combinational response of the function to dut_in
//   busy      out  sweep in progress
//   done      out  sweep complete, held until next start or reset
//   pass      out  valid with done, 1 when no mismatch was seen
//   err_cnt   out  number of mismatching vectors
//   fail_idx  out  first mismatching vector index, 0 if none
//   sig       out  MISR signature (only with TTAB_SIGNATURE_EN)
// ---------------------------------------------------------------------------
module ttab_bist_ctrl
  import ttab_pkg::*;
#(
  parameter int                  N_IN   = 4,
  parameter logic [2**N_IN-1:0]  EXP_TT = 16'hF830
)
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic [N_IN-1:0] fail_idx
`ifdef TTAB_SIGNATURE_EN
  ,
  output logic [15:0]     sig
`endif
);

  localparam logic [N_IN-1:0] LAST_VEC = '1;

  ttab_state_e   state;
  logic          mismatch;
  logic [N_IN:0] err_next;

  // The response for the vector currently on dut_in is checked against the
  // table bit at that index; err_next is the count including this vector,
  // which is what pass must reflect on the final edge.
  always_comb begin
    mismatch = dut_out ^ EXP_TT[dut_in];
    err_next = err_cnt + {{N_IN{1'b0}}, mismatch};
  end

  // Controller FSM with all outputs registered. A start from IDLE or DONE
  // clears the previous result on the same edge; while running, one vector
  // is compared per clock and the last comparison moves to DONE. A zero
  // error count before this vector identifies the first mismatch, so no
  // separate "seen" flag is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      dut_in   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      err_cnt  <= '0;
      fail_idx <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= RUN;
            dut_in   <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_cnt  <= '0;
            fail_idx <= '0;
          end
        end
        RUN: begin
          err_cnt <= err_next;
          if (mismatch && (err_cnt == '0)) begin
            fail_idx <= dut_in;
          end
          if (dut_in == LAST_VEC) begin
            state  <= DONE;
            dut_in <= '0;
            busy   <= 1'b0;
            done   <= 1'b1;
            pass   <= (err_next == '0);
          end else begin
            dut_in <= dut_in + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef TTAB_SIGNATURE_EN
  // Signature is reseeded on the edge that starts a sweep and folds in one
  // response bit per running edge, holding once the sweep has finished.
  ttab_misr u_misr (
    .clk       (clk),
    .rst_n     (rst_n),
    .seed_load ((state != RUN) && start),
    .shift_en  (state == RUN),
    .din       (dut_out),
    .sig       (sig)
  );
`else
  // Without the signature feature there is no MISR and no sig port.
`endif

endmodule

// File: tb/tb_ttab_bist_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ttab_bist_ctrl
// Self-checking bench for ttab_bist_ctrl. A function under test is modelled
// as a truth table fut_tt driven combinationally from dut_in; expected
// results come from comparing whole tables (popcount / lowest differing bit).
// Define TTAB_SIGNATURE_EN to also check the signature output.
// ---------------------------------------------------------------------------
module tb_ttab_bist_ctrl;

  localparam int          N_IN   = 4;
  localparam logic [15:0] EXP_TT = 16'hF830;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [N_IN-1:0] dut_in;
  logic            dut_out;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_cnt;
  logic [N_IN-1:0] fail_idx;
`ifdef TTAB_SIGNATURE_EN
  logic [15:0]     sig;
`endif

  logic [15:0] fut_tt;
  int n_checks = 0;
  int n_fail   = 0;

  ttab_bist_ctrl #(.N_IN(N_IN), .EXP_TT(EXP_TT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .dut_in   (dut_in),
    .dut_out  (dut_out),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .err_cnt  (err_cnt),
    .fail_idx (fail_idx)
`ifdef TTAB_SIGNATURE_EN
    ,
    .sig      (sig)
`endif
  );

  // Combinational function under test.
  assign dut_out = fut_tt[dut_in];

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Reference results from whole-table comparison.
  function automatic int refErrCnt(input logic [15:0] tt);
    return $countones(tt ^ EXP_TT);
  endfunction

  function automatic int refFailIdx(input logic [15:0] tt);
    logic [15:0] diff;
    int idx;
    diff = tt ^ EXP_TT;
    idx  = 0;
    for (int i = 15; i >= 0; i--) begin
      if (diff[i]) idx = i;
    end
    return idx;
  endfunction

  // CRC-style compression of the response stream, index 0 first.
  function automatic logic [15:0] refSig(input logic [15:0] tt);
    logic [15:0] s;
    logic        fb;
    s = 16'hFFFF;
    for (int i = 0; i < 16; i++) begin
      fb = s[15] ^ tt[i];
      s  = {s[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return s;
  endfunction

  task automatic checkResult(input string tag, input logic [15:0] tt);
    checkOutput({tag, "_done"},     32'(done),     32'd1);
    checkOutput({tag, "_busy"},     32'(busy),     32'd0);
    checkOutput({tag, "_pass"},     32'(pass),     32'(refErrCnt(tt) == 0));
    checkOutput({tag, "_err_cnt"},  32'(err_cnt),  32'(refErrCnt(tt)));
    checkOutput({tag, "_fail_idx"}, 32'(fail_idx), 32'(refFailIdx(tt)));
    checkOutput({tag, "_dut_in"},   32'(dut_in),   32'd0);
`ifdef TTAB_SIGNATURE_EN
    checkOutput({tag, "_sig"},      32'(sig),      32'(refSig(tt)));
`endif
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_dut_in"},   32'(dut_in),   32'd0);
    checkOutput({tag, "_busy"},     32'(busy),     32'd0);
    checkOutput({tag, "_done"},     32'(done),     32'd0);
    checkOutput({tag, "_pass"},     32'(pass),     32'd0);
    checkOutput({tag, "_err_cnt"},  32'(err_cnt),  32'd0);
    checkOutput({tag, "_fail_idx"}, 32'(fail_idx), 32'd0);
`ifdef TTAB_SIGNATURE_EN
    checkOutput({tag, "_sig"},      32'(sig),      32'hFFFF);
`endif
  endtask

  // One full sweep with table tt; optionally pulse start mid-sweep, which
  // must be ignored. Checks vector sequence, busy span and final result.
  task automatic applyStimulus(input string tag, input logic [15:0] tt,
                               input bit poke_start);
    fut_tt = tt;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput({tag, "_entry_done"}, 32'(done), 32'd0);
    for (int i = 0; i < 16; i++) begin
      if (poke_start && i == 5) start = 1'b1;
      checkOutput($sformatf("%s_vec%0d", tag, i), 32'(dut_in), 32'(i));
      checkOutput($sformatf("%s_bd%0d", tag, i), 32'({busy, done}), 32'b10);
      @(negedge clk);
      start = 1'b0;
    end
    checkResult(tag, tt);
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    fut_tt = EXP_TT;

    // Reset while clocking.
    repeat (3) @(negedge clk);
    checkReset("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Golden function, then result must hold while idle.
    applyStimulus("golden", EXP_TT, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("hold_done", 32'(done), 32'd1);
    checkOutput("hold_pass", 32'(pass), 32'd1);

    // Stuck outputs.
    applyStimulus("tied0", 16'h0000, 1'b0);
    applyStimulus("tied1", 16'hFFFF, 1'b0);

    // Start pulsed mid-sweep is ignored; restart from DONE works.
    applyStimulus("poke", EXP_TT, 1'b1);
    applyStimulus("restart", EXP_TT, 1'b0);

    // Random functions under test, including single-bit faults.
    for (int k = 0; k < 6; k++) begin
      applyStimulus($sformatf("rand%0d", k), 16'($urandom), 1'b0);
    end
    for (int k = 0; k < 3; k++) begin
      applyStimulus($sformatf("flip%0d", k),
                    EXP_TT ^ (16'h1 << $urandom_range(15, 0)), 1'b0);
    end

    // Reset in the middle of a sweep.
    fut_tt = 16'h1234;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    checkOutput("midrst_pre_dut_in", 32'(dut_in), 32'd7);
    rst_n = 1'b0;
    #1;
    checkReset("midrst");
    repeat (2) @(negedge clk);
    checkReset("midrst_hold");
    rst_n = 1'b1;
    applyStimulus("after_rst", EXP_TT, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
